xunit_sha_round: RTL and testbench

- SHA-256 compression unit; sits directly downstream of the message-schedule unit.
- Consumes the W_t stream (one 32-bit word per cycle) plus the 8-word chaining value H.
- Runs ROUNDS compression rounds with an internal K_t ROM.
- Outputs the feed-forward digest H + final working state as 8 words, and flags completion on done.

---
 rtl/xunit_sha_round_if.sv | 36 +++
 rtl/xunit_sha_round.sv | 222 ++++++++++++++++++++++
 tb/tb_xunit_sha_round.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xunit_sha_round_if.sv
// Port bundle between the schedule unit/controller and xunit_sha_round.
// The chain0 request exists only when SHA_DIGEST_CHAIN_EN is defined.
interface xunit_sha_round_if #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32
);
  logic               running;
  logic               run;
  logic               done;
  logic [DELAY_W-1:0] delay0;
  logic [DATA_W-1:0]  in0, in1, in2, in3, in4, in5, in6, in7, in8;
  logic [DATA_W-1:0]  out0, out1, out2, out3, out4, out5, out6, out7;
`ifdef SHA_DIGEST_CHAIN_EN
  logic               chain0;
`endif

  modport master (
    output running, run, delay0,
    output in0, in1, in2, in3, in4, in5, in6, in7, in8,
`ifdef SHA_DIGEST_CHAIN_EN
    output chain0,
`endif
    input  done,
    input  out0, out1, out2, out3, out4, out5, out6, out7
  );

  modport slave (
    input  running, run, delay0,
    input  in0, in1, in2, in3, in4, in5, in6, in7, in8,
`ifdef SHA_DIGEST_CHAIN_EN
    input  chain0,
`endif
    output done,
    output out0, out1, out2, out3, out4, out5, out6, out7
  );
endinterface

// File: rtl/xunit_sha_round.sv
// SHA-256 compression unit: ROUNDS rounds over the W_t stream, feed-forward digest on out0..out7.
// Optional macro SHA_DIGEST_CHAIN_EN adds chain0 (reuse the previous digest as the next H).
module xunit_sha_round #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 32,
  parameter int ROUNDS  = 64
) (
  input  logic             clk,
  input  logic             rst,
  xunit_sha_round_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_LOAD  = 3'd2,
    S_ROUND = 3'd3,
    S_FINAL = 3'd4
  } state_t;

  localparam logic [5:0]         T_LAST     = 6'(ROUNDS - 1);
  localparam logic [DELAY_W-1:0] DELAY_ONE  = DELAY_W'(1);
  localparam logic [DELAY_W-1:0] DELAY_ZERO = {DELAY_W{1'b0}};
  localparam logic [DATA_W-1:0]  WORD_ZERO  = {DATA_W{1'b0}};

  localparam logic [DATA_W-1:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [DATA_W-1:0] big_sigma0(input logic [DATA_W-1:0] x);
    return {x[1:0], x[DATA_W-1:2]} ^ {x[12:0], x[DATA_W-1:13]} ^ {x[21:0], x[DATA_W-1:22]};
  endfunction

  function automatic logic [DATA_W-1:0] big_sigma1(input logic [DATA_W-1:0] x);
    return {x[5:0], x[DATA_W-1:6]} ^ {x[10:0], x[DATA_W-1:11]} ^ {x[24:0], x[DATA_W-1:25]};
  endfunction

  function automatic logic [DATA_W-1:0] choose(input logic [DATA_W-1:0] e, input logic [DATA_W-1:0] f,
                                               input logic [DATA_W-1:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [DATA_W-1:0] majority(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t             state_r, state_s;
  logic [DELAY_W-1:0] delay_r, delay_s;
  logic [5:0]         t_r;
  logic               done_r;
  logic [DATA_W-1:0]  wk_r  [8];
  logic [DATA_W-1:0]  hv_r  [8];
  logic [DATA_W-1:0]  out_r [8];
  logic [DATA_W-1:0]  in_s  [8];
  logic [DATA_W-1:0]  src_s [8];
  logic [DATA_W-1:0]  t1_s, t2_s;
  logic               unused_s;

  assign unused_s = bus.running;

  assign in_s[0] = bus.in0;
  assign in_s[1] = bus.in1;
  assign in_s[2] = bus.in2;
  assign in_s[3] = bus.in3;
  assign in_s[4] = bus.in4;
  assign in_s[5] = bus.in5;
  assign in_s[6] = bus.in6;
  assign in_s[7] = bus.in7;

`ifdef SHA_DIGEST_CHAIN_EN
  logic chain_r;

  // chain0 request captured on the run cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      chain_r <= 1'b0;
    end else if (bus.run) begin
      chain_r <= bus.chain0;
    end else begin
      chain_r <= chain_r;
    end
  end

  // LOAD source: previous digest when chaining, otherwise the external H
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      if (chain_r) begin
        src_s[i] = out_r[i];
      end else begin
        src_s[i] = in_s[i];
      end
    end
  end
`else
  // LOAD source: always the external H
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      src_s[i] = in_s[i];
    end
  end
`endif

  // one compression round from the current working state
  always_comb begin
    t1_s = wk_r[7] + big_sigma1(wk_r[4]) + choose(wk_r[4], wk_r[5], wk_r[6]) + K_ROM[t_r] + bus.in8;
    t2_s = big_sigma0(wk_r[0]) + majority(wk_r[0], wk_r[1], wk_r[2]);
  end

  // state and wait-counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= S_IDLE;
      delay_r <= DELAY_ZERO;
    end else begin
      state_r <= state_s;
      delay_r <= delay_s;
    end
  end

  // WAIT spans exactly delay0 cycles so LOAD lands run+1+delay0; a zero delay skips it
  always_comb begin
    state_s = state_r;
    delay_s = delay_r;
    if (bus.run) begin
      delay_s = bus.delay0;
      if (bus.delay0 == DELAY_ZERO) begin
        state_s = S_LOAD;
      end else begin
        state_s = S_WAIT;
      end
    end else begin
      case (state_r)
        S_IDLE:  state_s = S_IDLE;
        S_WAIT: begin
          if (delay_r > DELAY_ONE) begin
            delay_s = delay_r - DELAY_ONE;
            state_s = S_WAIT;
          end else begin
            delay_s = DELAY_ZERO;
            state_s = S_LOAD;
          end
        end
        S_LOAD:  state_s = S_ROUND;
        S_ROUND: begin
          if (t_r == T_LAST) begin
            state_s = S_FINAL;
          end else begin
            state_s = S_ROUND;
          end
        end
        S_FINAL: state_s = S_IDLE;
        default: state_s = S_IDLE;
      endcase
    end
  end

  // working state, chaining value, round counter, digest and done
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      t_r    <= 6'd0;
      done_r <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        wk_r[i]  <= WORD_ZERO;
        hv_r[i]  <= WORD_ZERO;
        out_r[i] <= WORD_ZERO;
      end
    end else if (bus.run) begin
      done_r <= 1'b0;
    end else begin
      case (state_r)
        S_LOAD: begin
          t_r <= 6'd0;
          for (int i = 0; i < 8; i++) begin
            wk_r[i] <= src_s[i];
            hv_r[i] <= src_s[i];
          end
        end
        S_ROUND: begin
          wk_r[7] <= wk_r[6];
          wk_r[6] <= wk_r[5];
          wk_r[5] <= wk_r[4];
          wk_r[4] <= wk_r[3] + t1_s;
          wk_r[3] <= wk_r[2];
          wk_r[2] <= wk_r[1];
          wk_r[1] <= wk_r[0];
          wk_r[0] <= t1_s + t2_s;
          if (t_r == T_LAST) begin
            t_r <= t_r;
          end else begin
            t_r <= t_r + 6'd1;
          end
        end
        S_FINAL: begin
          done_r <= 1'b1;
          for (int i = 0; i < 8; i++) begin
            out_r[i] <= hv_r[i] + wk_r[i];
          end
        end
        default: t_r <= t_r;
      endcase
    end
  end

  assign bus.done = done_r;
  assign bus.out0 = out_r[0];
  assign bus.out1 = out_r[1];
  assign bus.out2 = out_r[2];
  assign bus.out3 = out_r[3];
  assign bus.out4 = out_r[4];
  assign bus.out5 = out_r[5];
  assign bus.out6 = out_r[6];
  assign bus.out7 = out_r[7];

endmodule

// File: tb/tb_xunit_sha_round.sv
// Randomized self-checking bench for xunit_sha_round against a plain SHA-256 compression model.
// Exercises the SHA_DIGEST_CHAIN_EN two-block vector when that macro is defined.
module tb_xunit_sha_round;

  typedef logic [0:7][31:0]  vec8_t;
  typedef logic [0:63][31:0] wsch_t;
  typedef logic [0:15][31:0] blk_t;

  logic        clk = 1'b0;
  logic        rst;
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] kt [64];

  xunit_sha_round_if #(.DATA_W(32), .DELAY_W(32)) bus ();
  xunit_sha_round_if #(.DATA_W(32), .DELAY_W(32)) bus1 ();

  xunit_sha_round #(.DATA_W(32), .DELAY_W(32), .ROUNDS(64)) dut (.clk(clk), .rst(rst), .bus(bus));
  xunit_sha_round #(.DATA_W(32), .DELAY_W(32), .ROUNDS(1))  dut1 (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic wsch_t expand(input blk_t m);
    wsch_t w;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = m[t];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    return w;
  endfunction

  function automatic vec8_t compress(input vec8_t h, input wsch_t w, input int rounds);
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    vec8_t r;
    for (int i = 0; i < 8; i++) v[i] = h[i];
    for (int t = 0; t < rounds; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kt[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[i] = h[i] + v[i];
    return r;
  endfunction

  function automatic vec8_t rand_vec();
    vec8_t r;
    for (int i = 0; i < 8; i++) r[i] = $urandom();
    return r;
  endfunction

  function automatic wsch_t rand_w();
    wsch_t r;
    for (int t = 0; t < 64; t++) r[t] = $urandom();
    return r;
  endfunction

  function automatic vec8_t get_out();
    return {bus.out0, bus.out1, bus.out2, bus.out3, bus.out4, bus.out5, bus.out6, bus.out7};
  endfunction

  function automatic vec8_t get_out1();
    return {bus1.out0, bus1.out1, bus1.out2, bus1.out3, bus1.out4, bus1.out5, bus1.out6, bus1.out7};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic check_vec(input string tag, input vec8_t obs, input vec8_t exp);
    for (int i = 0; i < 8; i++) check($sformatf("%s_out%0d", tag, i), obs[i], exp[i]);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_h(input vec8_t h);
    {bus.in0, bus.in1, bus.in2, bus.in3, bus.in4, bus.in5, bus.in6, bus.in7} = h;
  endtask

  // cycle T: run pulse; returns at cycle T+1
  task automatic start(input int d0, input bit chain);
    bus.run    = 1'b1;
    bus.delay0 = 32'(d0);
`ifdef SHA_DIGEST_CHAIN_EN
    bus.chain0 = chain;
`endif
    bus.in8 = $urandom();
    drive_h(rand_vec());
    tick();
    bus.run    = 1'b0;
    bus.delay0 = $urandom();
`ifdef SHA_DIGEST_CHAIN_EN
    bus.chain0 = ~chain;
`endif
  endtask

  // cycles T+1 .. T+1+d0+nrounds: wait garbage, LOAD with H, then W_0..W_{nrounds-1}
  task automatic feed(input vec8_t h, input wsch_t w, input int d0, input bit chain, input int nrounds,
                      inout int busy);
    for (int k = 0; k < d0; k++) begin
      if (bus.done !== 1'b0) busy++;
      bus.in8 = 32'hdeadbeef;
      drive_h(rand_vec());
      tick();
    end
    if (bus.done !== 1'b0) busy++;
    bus.in8 = $urandom();
    if (chain) drive_h(rand_vec());
    else drive_h(h);
    tick();
    for (int t = 0; t < nrounds; t++) begin
      if (bus.done !== 1'b0) busy++;
      bus.in8 = w[t];
      drive_h(rand_vec());
      tick();
    end
  endtask

  task automatic run_block(input string tag, input vec8_t h, input wsch_t w, input int d0, input bit chain,
                           input vec8_t exp);
    int busy = 0;
    start(d0, chain);
    feed(h, w, d0, chain, 64, busy);
    if (bus.done !== 1'b0) busy++;
    bus.in8 = $urandom();
    tick();
    check({tag, "_busy_cycles"}, 32'(busy), 32'd0);
    check({tag, "_done"}, {31'd0, bus.done}, 32'd1);
    check_vec(tag, get_out(), exp);
  endtask

  initial begin
    vec8_t iv, abc_exp, h, e, prev;
    wsch_t abc_w, w;
    blk_t  blk;
    int    busy;

    kt = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    iv = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    abc_exp = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
    blk = '0;
    blk[0]  = 32'h61626380;
    blk[15] = 32'h00000018;
    abc_w = expand(blk);

    rst = 1'b0;
    bus.running = 1'b0; bus.run = 1'b0; bus.delay0 = 32'd0; bus.in8 = 32'd0; drive_h('0);
    bus1.running = 1'b1; bus1.run = 1'b0; bus1.delay0 = 32'd0; bus1.in8 = 32'd0;
    {bus1.in0, bus1.in1, bus1.in2, bus1.in3, bus1.in4, bus1.in5, bus1.in6, bus1.in7} = '0;
`ifdef SHA_DIGEST_CHAIN_EN
    bus.chain0 = 1'b0;
    bus1.chain0 = 1'b0;
`endif
    repeat (3) tick();
    rst = 1'b1;
    tick();
    check_vec("reset", get_out(), '0);
    check("reset_done", {31'd0, bus.done}, 32'd1);

    run_block("abc", iv, abc_w, 0, 1'b0, abc_exp);
    repeat (5) tick();
    check_vec("hold", get_out(), abc_exp);
    check("hold_done", {31'd0, bus.done}, 32'd1);

    run_block("abc_d5", iv, abc_w, 5, 1'b0, abc_exp);

    for (int r = 0; r < 5; r++) begin
      h = rand_vec();
      w = rand_w();
      run_block($sformatf("rnd%0d", r), h, w, int'($urandom_range(0, 6)), 1'b0, compress(h, w, 64));
    end

    // second run arrives during round 10 of an abandoned operation
    prev = get_out();
    busy = 0;
    start(2, 1'b0);
    feed(rand_vec(), rand_w(), 2, 1'b0, 10, busy);
    check("restart_keep_out0", bus.out0, prev[0]);
    check("restart_first_busy", 32'(busy), 32'd0);
    run_block("restart", iv, abc_w, 3, 1'b0, abc_exp);

    // asynchronous reset during round 30
    busy = 0;
    start(0, 1'b0);
    feed(rand_vec(), rand_w(), 0, 1'b0, 30, busy);
    rst = 1'b0;
    #1;
    check_vec("async_rst", get_out(), '0);
    check("async_rst_done", {31'd0, bus.done}, 32'd1);
    #2;
    rst = 1'b1;
    tick();
    run_block("post_rst", iv, abc_w, 0, 1'b0, abc_exp);

    // single-round instance: spec vector, then a random one
    for (int rep = 0; rep < 2; rep++) begin
      w = '0;
      if (rep == 0) begin
        h = '0;
        e = '0;
        e[0] = 32'h428a2f98;
        e[4] = 32'h428a2f98;
      end else begin
        h = rand_vec();
        w[0] = $urandom();
        e = compress(h, w, 1);
      end
      bus1.run = 1'b1;
      tick();
      bus1.run = 1'b0;
      {bus1.in0, bus1.in1, bus1.in2, bus1.in3, bus1.in4, bus1.in5, bus1.in6, bus1.in7} = h;
      tick();
      {bus1.in0, bus1.in1, bus1.in2, bus1.in3, bus1.in4, bus1.in5, bus1.in6, bus1.in7} = rand_vec();
      bus1.in8 = w[0];
      check($sformatf("r1_%0d_busy", rep), {31'd0, bus1.done}, 32'd0);
      tick();
      bus1.in8 = $urandom();
      tick();
      check($sformatf("r1_%0d_done", rep), {31'd0, bus1.done}, 32'd1);
      check_vec($sformatf("r1_%0d", rep), get_out1(), e);
    end

`ifdef SHA_DIGEST_CHAIN_EN
    blk = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869, 32'h6768696a,
            32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f, 32'h6d6e6f70, 32'h6e6f7071,
            32'h80000000, 32'h00000000};
    w = expand(blk);
    run_block("chain_blk1", iv, w, 1, 1'b0, compress(iv, w, 64));
    blk = '0;
    blk[15] = 32'h000001c0;
    e = '{32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
          32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
    run_block("chain_blk2", rand_vec(), expand(blk), 0, 1'b1, e);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
